cube: RTL

CUBE -- requirements
Module: cube

---
 rtl/cube_if.sv | 19 +
 rtl/cube.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cube_if.sv
//------------------------------------------------------------------------------
// Module : cube_if
// Brief  : Request/result bundle for the cube unit. The master drives
//          start and the operand. The slave returns result and busy.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cube_if;
  logic        start;
  logic [7:0]  x_i;
  logic [23:0] result;
  logic        busy;

  modport master (output start, output x_i, input  result, input  busy);
  modport slave  (input  start, input  x_i, output result, output busy);
endinterface

`default_nettype wire

// File: rtl/cube.sv
//------------------------------------------------------------------------------
// Module : cube
// Brief  : Computes the unsigned cube of an 8-bit operand with one shared
//          24-bit adder. Phase SQ forms x*x over 8 shift-add cycles. Phase CB
//          forms (x*x)*x over another 8 cycles. The result register changes
//          only when an operation completes.
// Macro  : CUBE_EARLY_EXIT_EN - when defined, operands 0 and 1 bypass the
//          shift-add phases through a one-cycle DONE state.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cube (
  input  logic   clk,
  input  logic   rst,
  cube_if.slave  bus
);

`ifdef CUBE_EARLY_EXIT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    CB   = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    CB   = 2'd2
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  x_q;
  logic [23:0] acc_q;
  logic [15:0] sq_q;
  logic [2:0]  i_q;
  logic [23:0] result_q;

  logic [23:0] addend;
  logic [23:0] sum;
  logic        last_bit;
  logic        early;

  // The single adder is shared by both phases. Only the shifted operand changes.
  always_comb begin
    addend   = (state_q == CB) ? ({8'd0, sq_q} << i_q) : ({16'd0, x_q} << i_q);
    sum      = acc_q + addend;
    last_bit = (i_q == 3'd7);
`ifdef CUBE_EARLY_EXIT_EN
    early    = (bus.x_i <= 8'd1);
`else
    early    = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode. Each phase ends after its eighth bit, when i is 7.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef CUBE_EARLY_EXIT_EN
          state_d = early ? DONE : SQ;
`else
          state_d = SQ;
`endif
        end
      end
      SQ:      if (last_bit) state_d = CB;
      CB:      if (last_bit) state_d = IDLE;
`ifdef CUBE_EARLY_EXIT_EN
      DONE:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath. Operands are captured on acceptance. Bits are processed LSB first.
  // i wraps from 7 to 0 by itself at each phase boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= 8'd0;
      acc_q    <= 24'd0;
      sq_q     <= 16'd0;
      i_q      <= 3'd0;
      result_q <= 24'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_q   <= bus.x_i;
            acc_q <= 24'd0;
            sq_q  <= 16'd0;
            i_q   <= 3'd0;
          end
        end
        SQ: begin
          i_q <= i_q + 3'd1;
          if (last_bit) begin
            // x*x never exceeds 16 bits, so the upper accumulator bits are zero here.
            sq_q  <= x_q[i_q] ? sum[15:0] : acc_q[15:0];
            acc_q <= 24'd0;
          end else if (x_q[i_q]) begin
            acc_q <= sum;
          end
        end
        CB: begin
          i_q <= i_q + 3'd1;
          if (x_q[i_q]) acc_q <= sum;
          if (last_bit) result_q <= x_q[i_q] ? sum : acc_q;
        end
`ifdef CUBE_EARLY_EXIT_EN
        DONE: result_q <= {16'd0, x_q};
`endif
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state_q != IDLE);

  // Early-exit decode is unused when the bypass is compiled out.
  logic unused_early;
  assign unused_early = early;

endmodule

`default_nettype wire
